// File: rtl/cnn_wr_packer_pkg.sv
// Shared definitions for the CNN result write path: line geometry and packer FSM states.
package cnn_wr_packer_pkg;

  localparam int WR_WORD_WIDTH     = 8;
  localparam int WR_WORDS_PER_LINE = 32;
  localparam int WR_LINE_WIDTH     = WR_WORDS_PER_LINE * WR_WORD_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } wr_state_e;

endpackage

// File: rtl/cnn_wr_line_acc.sv
// Byte accumulator for one memory line: slot write, fill count and full/final detection.
module cnn_wr_line_acc
  import cnn_wr_packer_pkg::*;
#(
  parameter int WORD_WIDTH = WR_WORD_WIDTH,
  parameter int NUM_WORDS  = WR_WORDS_PER_LINE,
  parameter int CW         = $clog2(NUM_WORDS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_i,
  input  logic                            wr_en_i,
  input  logic [WORD_WIDTH-1:0]           wr_data_i,
  input  logic                            wr_last_i,
  input  logic                            take_i,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] line_o,
  output logic [CW-1:0]                   size_o,
  output logic                            full_o,
  output logic                            final_o
);

  localparam int IW = $clog2(NUM_WORDS);

  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] data_q;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] merged;
  logic [CW-1:0]                        cnt_q;
  logic                                 full_q;

  // A byte accepted into a full accumulator only happens while that line is being taken,
  // so "final" is only evaluated for a non-full accumulator.
  assign final_o = wr_en_i && !full_q &&
                   ((cnt_q == CW'(NUM_WORDS - 1)) || wr_last_i);

  always_comb begin
    merged = data_q;
    if (wr_en_i && !full_q) merged[cnt_q[IW-1:0]] = wr_data_i;
  end

  assign line_o = merged;
  assign size_o = full_q ? cnt_q : cnt_q + CW'(1);
  assign full_o = full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (take_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      if (wr_en_i && full_q) begin
        data_q[0] <= wr_data_i;
        cnt_q     <= CW'(1);
        full_q    <= wr_last_i;
      end
    end else if (wr_en_i) begin
      data_q[cnt_q[IW-1:0]] <= wr_data_i;
      cnt_q                 <= cnt_q + CW'(1);
      full_q                <= final_o;
    end
  end

endmodule

// File: rtl/cnn_wr_packer.sv
// Packs activation bytes into 32-byte lines and issues one write request per line.
//   state    | meaning
//   ST_IDLE  | waiting for go; res_ready low
//   ST_FILL  | accepting bytes, emitting full lines
//   ST_DRAIN | res_last accepted; flushing remaining lines until final ack
module cnn_wr_packer
  import cnn_wr_packer_pkg::*;
#(
  parameter int ADDR_WIDTH        = 19,
  parameter int WORD_WIDTH        = WR_WORD_WIDTH,
  parameter int NUM_WORDS_IN_LINE = WR_WORDS_PER_LINE
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ADDR_WIDTH-1:0]                   sw_cnn_addr_z,
  input  logic                                    go,
  input  logic                                    res_valid,
  input  logic [WORD_WIDTH-1:0]                   res_data,
  input  logic                                    res_last,
  output logic                                    res_ready,
  output logic                                    mem_req,
  output logic [ADDR_WIDTH-1:0]                   mem_start_addr,
  output logic [5:0]                              mem_size_bytes,
  output logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] mem_data,
  output logic [4:0]                              mem_last_valid,
  input  logic                                    mem_ack,
  output logic                                    busy,
  output logic                                    done
);

  localparam int CW = $clog2(NUM_WORDS_IN_LINE + 1);
  localparam int LW = NUM_WORDS_IN_LINE * WORD_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(LW / 8);

  wr_state_e             state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [5:0]            mem_size_q;
  logic [4:0]            mem_lv_q;
  logic [LW-1:0]         mem_data_q;

  logic          ack_c, start_c, accept_c, take_c;
  logic [LW-1:0] acc_line;
  logic [CW-1:0] acc_size;
  logic          acc_full, acc_final;

  assign ack_c    = mem_req_q && mem_ack;
  assign start_c  = (state_q == ST_IDLE) && go;
  assign res_ready = (state_q == ST_FILL) && !(acc_full && mem_req_q && !ack_c);
  assign accept_c = res_valid && res_ready;
  // The holding register is the mem_* output set; it frees on ack and may refill in that same cycle.
  assign take_c   = (acc_final || acc_full) && (!mem_req_q || ack_c);

  cnn_wr_line_acc #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS_IN_LINE),
    .CW         (CW)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start_c),
    .wr_en_i   (accept_c),
    .wr_data_i (res_data),
    .wr_last_i (res_last),
    .take_i    (take_c),
    .line_o    (acc_line),
    .size_o    (acc_size),
    .full_o    (acc_full),
    .final_o   (acc_final)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (go) state_d = ST_FILL;
      ST_FILL:  if (accept_c && res_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ack_c && !acc_full) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      addr_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_size_q <= '0;
      mem_lv_q   <= '0;
      mem_data_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_c)     addr_q <= sw_cnn_addr_z;
      else if (take_c) addr_q <= addr_q + STRIDE;
      if (take_c) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= addr_q;
        mem_size_q <= 6'(acc_size);
        mem_lv_q   <= 5'(acc_size - CW'(1));
        mem_data_q <= acc_line;
      end else if (ack_c) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_start_addr = mem_addr_q;
  assign mem_size_bytes = mem_size_q;
  assign mem_last_valid = mem_lv_q;
  assign mem_data       = mem_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_cnn_wr_packer.sv
// Scoreboard bench for cnn_wr_packer: expected lines are queued by the stimulus, a monitor checks requests.
module tb_cnn_wr_packer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [18:0]   sw_cnn_addr_z;
  logic          go;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_last;
  logic          res_ready;
  logic          mem_req;
  logic [18:0]   mem_start_addr;
  logic [5:0]    mem_size_bytes;
  logic [255:0]  mem_data;
  logic [4:0]    mem_last_valid;
  logic          mem_ack;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 1;
  bit ack_en    = 1'b1;

  typedef struct {
    logic [18:0]  addr;
    logic [5:0]   size;
    logic [255:0] data;
  } line_t;

  line_t expq[$];

  cnn_wr_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_cnn_addr_z  (sw_cnn_addr_z),
    .go             (go),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_last       (res_last),
    .res_ready      (res_ready),
    .mem_req        (mem_req),
    .mem_start_addr (mem_start_addr),
    .mem_size_bytes (mem_size_bytes),
    .mem_data       (mem_data),
    .mem_last_valid (mem_last_valid),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [18:0] addr, input int size, input int first_val);
    line_t l;
    l.addr = addr;
    l.size = 6'(size);
    l.data = '0;
    for (int k = 0; k < size; k++) l.data[8*k +: 8] = 8'(first_val + k);
    expq.push_back(l);
  endtask

  task automatic pulse_go(input logic [18:0] addr);
    sw_cnn_addr_z = addr;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int first_val, input bit with_last, output int stall_at);
    stall_at = -1;
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      res_valid = 1'b1;
      res_data  = 8'(first_val + i);
      res_last  = with_last && (i == n - 1);
      @(negedge clk);
      while (!res_ready && guard <= 200) begin
        if (stall_at < 0) stall_at = i;
        guard++;
        @(negedge clk);
      end
      if (!res_ready) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout byte=%0d actual=0 required=1", i);
        res_valid = 1'b0;
        res_last  = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    chk({name, "_queue_empty"}, expq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"},   mem_req, 0);
    chk({tag, "_mem_addr"},  mem_start_addr, 0);
    chk({tag, "_mem_size"},  mem_size_bytes, 0);
    chk({tag, "_mem_data"},  mem_data, 0);
    chk({tag, "_mem_lv"},    mem_last_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
  endtask

  // Memory responder: acks after ack_delay cycles of an observed request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req && ack_en) begin
        if (wait_cnt >= ack_delay) mem_ack = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every request cycle must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual_addr=%0h actual_size=%0d required=none",
                   mem_start_addr, mem_size_bytes);
        end else begin
          chk("mem_addr", mem_start_addr, expq[0].addr);
          chk("mem_size", mem_size_bytes, expq[0].size);
          chk("mem_last_valid", mem_last_valid, expq[0].size - 6'd1);
          chk("mem_data", mem_data, expq[0].data);
          if (mem_ack) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    int stall;
    rst_n = 1'b0;
    sw_cnn_addr_z = '0;
    go = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    res_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full lines, ack one cycle after req.
    push_line(19'h100, 32, 0);
    push_line(19'h120, 32, 32);
    pulse_go(19'h100);
    chk("busy_after_go", busy, 1'b1);
    send_bytes(64, 0, 1'b1, stall);
    chk("no_stall_fast_ack", stall, -1);
    wait_done("two_lines", 200);

    // Short job: five bytes, unfilled lanes zero.
    push_line(19'h3000, 5, 8'hA0);
    pulse_go(19'h3000);
    send_bytes(5, 8'hA0, 1'b1, stall);
    wait_done("five_bytes", 100);

    // Last on the 32nd byte: exactly one full line, nothing afterwards.
    push_line(19'h400, 32, 8'h40);
    pulse_go(19'h400);
    send_bytes(32, 8'h40, 1'b1, stall);
    wait_done("last_on_32", 100);
    repeat (10) @(posedge clk);
    #1;
    chk("no_extra_req", mem_req, 1'b0);

    // Slow memory: ack withheld for 40 cycles, stream must stall after 64 bytes.
    ack_delay = 40;
    push_line(19'h800, 32, 8'h10);
    push_line(19'h820, 32, 8'h30);
    push_line(19'h840, 32, 8'h50);
    pulse_go(19'h800);
    send_bytes(96, 8'h10, 1'b1, stall);
    chk("stall_after_64", stall, 64);
    wait_done("slow_ack", 400);
    ack_delay = 1;

    // go while busy is ignored; address keeps counting from the original base.
    push_line(19'h1000, 32, 0);
    push_line(19'h1020, 5, 32);
    pulse_go(19'h1000);
    send_bytes(10, 0, 1'b0, stall);
    pulse_go(19'h5000);
    chk("busy_after_ignored_go", busy, 1'b1);
    send_bytes(27, 10, 1'b1, stall);
    wait_done("go_while_busy", 200);

    // Address wraps modulo 2^19.
    push_line(19'h7FFF0, 32, 8'h80);
    push_line(19'h00010, 8, 8'hA0);
    pulse_go(19'h7FFF0);
    send_bytes(40, 8'h80, 1'b1, stall);
    wait_done("addr_wrap", 200);

    // Reset while a request is outstanding, then a clean restart.
    ack_en = 1'b0;
    push_line(19'h600, 32, 0);
    pulse_go(19'h600);
    send_bytes(32, 0, 1'b0, stall);
    begin
      int n;
      n = 0;
      while (!mem_req && n < 10) begin
        n++;
        @(posedge clk); #1;
      end
    end
    chk("req_before_reset", mem_req, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_outputs_zero("mid_reset");
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    push_line(19'h200, 3, 8'hC0);
    pulse_go(19'h200);
    send_bytes(3, 8'hC0, 1'b1, stall);
    wait_done("restart", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
